// File: rtl/regfile_banked.sv
// regfile_banked: 2**A x W register file with NRD combinational read ports,
// live accumulator (R0) and branch-register (R1) outputs, and a shadow bank
// filled/drained one register per cycle by a save/restore engine.
//
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted
// same-cycle write onto every read path (general ports, R0 and R1 outputs).
// With the macro undefined, reads always return the pre-edge contents.
module regfile_banked #(
  parameter int W   = 8,
  parameter int A   = 4,
  parameter int NRD = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NRD*A-1:0]   Raddr,
  output logic [NRD*W-1:0]   DataOut,
  output logic [W-1:0]       DataOutAccumulator,
  output logic [W-1:0]       DataOutBranchReg,
  input  logic               WriteR0,
  input  logic               GenRegWrite,
  input  logic [A-1:0]       Waddr,
  input  logic [W-1:0]       DataIn,
  input  logic               BranchLoad,
  input  logic [W-1:0]       Target,
  input  logic               SaveReq,
  input  logic               RestoreReq,
  output logic               Busy,
  output logic               Done,
  output logic               WrErr
);

  localparam int         DEPTH    = 2 ** A;
  localparam logic [A:0] LAST_IDX = (A + 1)'(DEPTH - 1);
  localparam logic [A:0] ONE_IDX  = (A + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [A:0]     idx_q, idx_d;
  logic           wrerr_q, wrerr_d;
  logic [W-1:0]   live_q   [DEPTH];
  logic [W-1:0]   live_d   [DEPTH];
  logic [W-1:0]   shadow_q [DEPTH];
  logic [W-1:0]   shadow_d [DEPTH];

  logic           idle_s;
  logic           busy_s;
  logic           any_wr_s;
  logic           we_s     [DEPTH];
  logic [W-1:0]   wdata_s  [DEPTH];
  logic [W-1:0]   view_s   [DEPTH];
  logic [A-1:0]   cidx_s;

  assign idle_s   = (state_q == ST_IDLE);
  assign busy_s   = !idle_s;
  assign any_wr_s = WriteR0 | GenRegWrite | BranchLoad;
  assign cidx_s   = idx_q[A-1:0];

  // Resolve the per-register write enables and data, applying the R0 / R1 priorities.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      we_s[j]    = 1'b0;
      wdata_s[j] = DataIn;
      if (!idle_s) begin
        we_s[j]    = 1'b0;
        wdata_s[j] = DataIn;
      end else if ((j == 1) && BranchLoad) begin
        we_s[j]    = 1'b1;
        wdata_s[j] = Target;
      end else if ((j == 0) && WriteR0) begin
        we_s[j]    = 1'b1;
        wdata_s[j] = DataIn;
      end else if (GenRegWrite && !WriteR0 && (Waddr == A'(j))) begin
        we_s[j]    = 1'b1;
        wdata_s[j] = DataIn;
      end else begin
        we_s[j]    = 1'b0;
        wdata_s[j] = DataIn;
      end
    end
  end

  // Next-state logic: IDLE writes and request acceptance, one-register-per-cycle copy while busy.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrerr_d = wrerr_q;
    for (int j = 0; j < DEPTH; j++) begin
      live_d[j]   = live_q[j];
      shadow_d[j] = shadow_q[j];
    end

    case (state_q)
      ST_IDLE: begin
        for (int j = 0; j < DEPTH; j++) begin
          if (we_s[j]) begin
            live_d[j] = wdata_s[j];
          end else begin
            live_d[j] = live_q[j];
          end
        end
        idx_d = '0;
        if (SaveReq) begin
          state_d = ST_SAVE;
        end else if (RestoreReq) begin
          state_d = ST_RESTORE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SAVE, ST_RESTORE: begin
        if (state_q == ST_SAVE) begin
          shadow_d[cidx_s] = live_q[cidx_s];
        end else begin
          live_d[cidx_s] = shadow_q[cidx_s];
        end
        // Writes are dropped while busy; remember that upstream failed to stall.
        if (any_wr_s) begin
          wrerr_d = 1'b1;
        end else begin
          wrerr_d = wrerr_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          state_d = state_q;
          idx_d   = idx_q + ONE_IDX;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, index, sticky error and both register banks; reset clears everything.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wrerr_q <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        live_q[j]   <= '0;
        shadow_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrerr_q <= wrerr_d;
      for (int j = 0; j < DEPTH; j++) begin
        live_q[j]   <= live_d[j];
        shadow_q[j] <= shadow_d[j];
      end
    end
  end

  // Read view of the live bank, optionally forwarding the accepted same-cycle write.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
`ifdef REGFILE_BYPASS_EN
      if (we_s[j]) begin
        view_s[j] = wdata_s[j];
      end else begin
        view_s[j] = live_q[j];
      end
`else
      view_s[j] = live_q[j];
`endif
    end
  end

  // General read ports, each selecting one register of the read view.
  always_comb begin
    DataOut = '0;
    for (int i = 0; i < NRD; i++) begin
      DataOut[i*W +: W] = view_s[Raddr[i*A +: A]];
    end
  end

  assign DataOutAccumulator = view_s[0];
  assign DataOutBranchReg   = view_s[1];
  assign Busy               = busy_s;
  assign Done               = busy_s && (idx_q == LAST_IDX);
  assign WrErr              = wrerr_q;

endmodule

// File: tb/tb_regfile_banked.sv
// Self-checking bench for regfile_banked (default parameters W=8, A=4, NRD=2).
// Directed table, hand-written save/restore/reset sequences and a random phase,
// all compared against a behavioural model of the register file.
module tb_regfile_banked;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  Raddr;
  logic [15:0] DataOut;
  logic [7:0]  DataOutAccumulator;
  logic [7:0]  DataOutBranchReg;
  logic        WriteR0;
  logic        GenRegWrite;
  logic [3:0]  Waddr;
  logic [7:0]  DataIn;
  logic        BranchLoad;
  logic [7:0]  Target;
  logic        SaveReq;
  logic        RestoreReq;
  logic        Busy;
  logic        Done;
  logic        WrErr;

  regfile_banked #(.W(8), .A(4), .NRD(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Raddr(Raddr), .DataOut(DataOut),
    .DataOutAccumulator(DataOutAccumulator), .DataOutBranchReg(DataOutBranchReg),
    .WriteR0(WriteR0), .GenRegWrite(GenRegWrite), .Waddr(Waddr), .DataIn(DataIn),
    .BranchLoad(BranchLoad), .Target(Target), .SaveReq(SaveReq), .RestoreReq(RestoreReq),
    .Busy(Busy), .Done(Done), .WrErr(WrErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: op 0 = idle, 1 = saving, 2 = restoring; k = registers copied so far.
  logic [7:0] m_live   [16];
  logic [7:0] m_shadow [16];
  logic [7:0] m_next   [16];
  int         m_op;
  int         m_k;
  logic       m_wrerr;

  logic s_busy, s_done;
  int   busy_seen, done_seen, done_at;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_live[i]   = 8'h00;
      m_shadow[i] = 8'h00;
    end
    m_op    = 0;
    m_k     = 0;
    m_wrerr = 1'b0;
  endtask

  // Register contents after this cycle's writes (applied in rising priority order).
  task automatic calc_next();
    for (int i = 0; i < 16; i++) m_next[i] = m_live[i];
    if (m_op == 0) begin
      if (GenRegWrite && !WriteR0) m_next[Waddr] = DataIn;
      if (WriteR0) m_next[0] = DataIn;
      if (BranchLoad) m_next[1] = Target;
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    return m_next[a];
`else
    return m_live[a];
`endif
  endfunction

  task automatic idle_in();
    WriteR0 = 1'b0; GenRegWrite = 1'b0; Waddr = 4'd0; DataIn = 8'h00;
    BranchLoad = 1'b0; Target = 8'h00; SaveReq = 1'b0; RestoreReq = 1'b0;
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic cycle();
    #1;
    calc_next();
    chk("rd0", DataOut[7:0], exp_rd(Raddr[3:0]));
    chk("rd1", DataOut[15:8], exp_rd(Raddr[7:4]));
    chk("acc", DataOutAccumulator, exp_rd(4'd0));
    chk("br", DataOutBranchReg, exp_rd(4'd1));
    chk("busy", {7'd0, Busy}, {7'd0, m_op != 0});
    chk("done", {7'd0, Done}, {7'd0, (m_op != 0) && (m_k == 15)});
    chk("wrerr", {7'd0, WrErr}, {7'd0, m_wrerr});
    s_busy = Busy;
    s_done = Done;
    if (s_busy) busy_seen++;
    if (s_done) begin
      done_seen++;
      done_at = busy_seen;
    end
    @(posedge Clk);
    if (m_op == 0) begin
      for (int i = 0; i < 16; i++) m_live[i] = m_next[i];
      m_k = 0;
      if (SaveReq) m_op = 1;
      else if (RestoreReq) m_op = 2;
    end else begin
      if (WriteR0 || GenRegWrite || BranchLoad) m_wrerr = 1'b1;
      if (m_op == 1) m_shadow[m_k] = m_live[m_k];
      else m_live[m_k] = m_shadow[m_k];
      m_k++;
      if (m_k == 16) begin
        m_op = 0;
        m_k  = 0;
      end
    end
    #1;
  endtask

  // Run idle cycles until the engine returns to idle (bounded).
  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (!s_busy) break;
    end
    chk("drain_timeout", {7'd0, s_busy}, 8'h00);
  endtask

  task automatic start_op(input logic sv, input logic rs);
    busy_seen = 0; done_seen = 0; done_at = 0;
    idle_in();
    SaveReq = sv; RestoreReq = rs;
    cycle();
    idle_in();
  endtask

  typedef struct {
    logic       wr0;
    logic       gen;
    logic [3:0] waddr;
    logic [7:0] din;
    logic       bl;
    logic [7:0] tgt;
    logic [3:0] caddr;
    logic [7:0] exp_rd;
    logic [7:0] exp_acc;
    logic [7:0] exp_br;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd5,  8'hA5, 1'b0, 8'h00, 4'd5,  8'h00, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 4'd1,  8'h11, 1'b1, 8'h3C, 4'd1,  8'h3C, 8'hA5, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 4'd0,  8'h42, 1'b0, 8'h00, 4'd0,  8'h42, 8'h42, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 4'd7,  8'h77, 1'b0, 8'h00, 4'd7,  8'h77, 8'h42, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 4'd1,  8'h99, 1'b0, 8'h00, 4'd1,  8'h99, 8'h42, 8'h99};
    vecs[5] = '{1'b1, 1'b0, 4'd0,  8'h5E, 1'b1, 8'hC3, 4'd7,  8'h77, 8'h5E, 8'hC3};
    vecs[6] = '{1'b0, 1'b1, 4'd15, 8'hF0, 1'b0, 8'h00, 4'd15, 8'hF0, 8'h5E, 8'hC3};

    Rst_n = 1'b0;
    Raddr = 8'h00;
    idle_in();
    model_reset();
    busy_seen = 0; done_seen = 0; done_at = 0;
    s_busy = 1'b0; s_done = 1'b0;

    // Reset state.
    #8;
    Raddr = 8'h9A;
    #1;
    chk("rst_rd0", DataOut[7:0], 8'h00);
    chk("rst_rd1", DataOut[15:8], 8'h00);
    chk("rst_acc", DataOutAccumulator, 8'h00);
    chk("rst_br", DataOutBranchReg, 8'h00);
    chk("rst_busy", {7'd0, Busy}, 8'h00);
    chk("rst_done", {7'd0, Done}, 8'h00);
    chk("rst_wrerr", {7'd0, WrErr}, 8'h00);
    #3;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed write-priority table.
    for (int v = 0; v < 7; v++) begin
      idle_in();
      WriteR0 = vecs[v].wr0; GenRegWrite = vecs[v].gen; Waddr = vecs[v].waddr;
      DataIn = vecs[v].din; BranchLoad = vecs[v].bl; Target = vecs[v].tgt;
      cycle();
      idle_in();
      Raddr = {4'd0, vecs[v].caddr};
      #1;
      chk($sformatf("vec%0d_rd", v), DataOut[7:0], vecs[v].exp_rd);
      chk($sformatf("vec%0d_acc", v), DataOutAccumulator, vecs[v].exp_acc);
      chk($sformatf("vec%0d_br", v), DataOutBranchReg, vecs[v].exp_br);
    end

    // Load R0..R15 with 0x10..0x1F, then save.
    for (int i = 0; i < 16; i++) begin
      idle_in();
      GenRegWrite = 1'b1; Waddr = 4'(i); DataIn = 8'(8'h10 + i);
      Raddr = {4'(i), 4'(15 - i)};
      cycle();
    end
    start_op(1'b1, 1'b0);
    drain();
    chk("save_busy_cycles", 8'(busy_seen), 8'd16);
    chk("save_done_count", 8'(done_seen), 8'd1);
    chk("save_done_at", 8'(done_at), 8'd16);

    // Clobber R3, restore, and confirm every register came back.
    idle_in();
    GenRegWrite = 1'b1; Waddr = 4'd3; DataIn = 8'hFF;
    cycle();
    start_op(1'b0, 1'b1);
    drain();
    chk("restore_busy_cycles", 8'(busy_seen), 8'd16);
    Raddr = 8'h03;
    #1;
    chk("restore_r3", DataOut[7:0], 8'h13);
    for (int i = 0; i < 16; i += 2) begin
      Raddr = {4'(i + 1), 4'(i)};
      cycle();
    end

    // Save and restore requested together: save wins.
    idle_in();
    GenRegWrite = 1'b1; Waddr = 4'd4; DataIn = 8'hAA;
    cycle();
    start_op(1'b1, 1'b1);
    drain();
    idle_in();
    GenRegWrite = 1'b1; Waddr = 4'd4; DataIn = 8'h00;
    cycle();
    start_op(1'b0, 1'b1);
    drain();
    Raddr = 8'h04;
    #1;
    chk("both_req_save_r4", DataOut[7:0], 8'hAA);

    // RestoreReq at busy cycle 5 ignored.
    start_op(1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cycle();
    RestoreReq = 1'b1;
    cycle();
    idle_in();
    drain();
    chk("ignored_req_busy_cycles", 8'(busy_seen), 8'd16);
    cycle();
    chk("ignored_req_stays_idle", {7'd0, s_busy}, 8'h00);

    // Write while busy at busy cycle 3.
    start_op(1'b1, 1'b0);
    cycle();
    cycle();
    GenRegWrite = 1'b1; Waddr = 4'd2; DataIn = 8'h77;
    cycle();
    idle_in();
    drain();
    Raddr = 8'h02;
    #1;
    chk("busy_write_r2", DataOut[7:0], 8'h12);
    chk("busy_write_wrerr", {7'd0, WrErr}, 8'h01);
    for (int c = 0; c < 3; c++) cycle();
    chk("wrerr_sticky", {7'd0, WrErr}, 8'h01);

    // Reset at busy cycle 7 of a save.
    start_op(1'b1, 1'b0);
    for (int c = 0; c < 6; c++) cycle();
    Raddr = 8'h25;
    #1;
    Rst_n = 1'b0;
    #1;
    chk("midrst_busy", {7'd0, Busy}, 8'h00);
    chk("midrst_done", {7'd0, Done}, 8'h00);
    chk("midrst_wrerr", {7'd0, WrErr}, 8'h00);
    chk("midrst_acc", DataOutAccumulator, 8'h00);
    chk("midrst_rd0", DataOut[7:0], 8'h00);
    chk("midrst_rd1", DataOut[15:8], 8'h00);
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 16; i += 2) begin
      Raddr = {4'(i + 1), 4'(i)};
      cycle();
    end
    start_op(1'b1, 1'b0);
    drain();
    chk("post_rst_save_cycles", 8'(busy_seen), 8'd16);

    // Same-cycle read of a register being written.
    idle_in();
    Raddr = 8'h04;
    GenRegWrite = 1'b1; Waddr = 4'd4; DataIn = 8'h5A;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", DataOut[7:0], 8'h5A);
`else
    chk("bypass_same_cycle", DataOut[7:0], 8'h00);
`endif
    cycle();
    idle_in();
    #1;
    chk("bypass_next_cycle", DataOut[7:0], 8'h5A);

    // Random phase.
    for (int n = 0; n < 400; n++) begin
      WriteR0     = ($urandom_range(0, 3) == 0);
      GenRegWrite = ($urandom_range(0, 1) == 0);
      Waddr       = 4'($urandom_range(0, 15));
      DataIn      = 8'($urandom);
      BranchLoad  = ($urandom_range(0, 3) == 0);
      Target      = 8'($urandom);
      SaveReq     = ($urandom_range(0, 19) == 0);
      RestoreReq  = ($urandom_range(0, 19) == 0);
      Raddr       = 8'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
